// File: rtl/loop_recorder.sv
`default_nettype none
// ============================================================================
// loop_recorder -- stereo loop capture/playback with fixed 2-cycle output path
// Revision 1.0
// ============================================================================
module loop_recorder #(
   parameter int ADDR_W = 10
) (
   input  logic              CLOCK_50,
   input  logic              reset_n,
   input  logic              sample_tick,
   input  logic [31:0]       left_channel_audio_in,
   input  logic [31:0]       right_channel_audio_in,
   input  logic              record,
   input  logic              play,
   output logic [31:0]       left_channel_audio_out,
   output logic [31:0]       right_channel_audio_out,
   output logic              sample_valid_out,
   output logic [ADDR_W:0]   loop_length,
   output logic [1:0]        state
);

   localparam int DEPTH = 1 << ADDR_W;
   localparam logic [ADDR_W:0] LEN_FULL = (ADDR_W+1)'(DEPTH);
   localparam logic [ADDR_W:0] LEN_LAST = (ADDR_W+1)'(DEPTH - 1);

   typedef enum logic [1:0] {
      S_IDLE   = 2'b00,
      S_RECORD = 2'b01,
      S_PLAY   = 2'b10
   } state_t;

   state_t              state_q, state_d;
   logic                record_q, record_d;
   logic [ADDR_W-1:0]   wr_ptr_q, wr_ptr_d;
   logic [ADDR_W-1:0]   rd_ptr_q, rd_ptr_d;
   logic [ADDR_W:0]     loop_len_q, loop_len_d;
   logic [63:0]         pass_q, pass_d;
   logic [63:0]         rd_data_q, rd_data_d;
   logic                stg_vld_q, stg_vld_d;
   logic                stg_play_q, stg_play_d;
   logic [63:0]         out_q, out_d;
   logic                vld_out_q, vld_out_d;

   logic [63:0]         mem [DEPTH];
   logic                mem_we;
   logic                rec_rise;
   logic [63:0]         sample_in;
   logic [ADDR_W:0]     len_minus1;

   assign sample_in  = {left_channel_audio_in, right_channel_audio_in};
   assign rec_rise   = record & ~record_q;
   assign len_minus1 = loop_len_q - 1'b1;

   always_comb begin
      state_d    = state_q;
      record_d   = record;
      wr_ptr_d   = wr_ptr_q;
      rd_ptr_d   = rd_ptr_q;
      loop_len_d = loop_len_q;
      pass_d     = pass_q;
      rd_data_d  = rd_data_q;
      mem_we     = 1'b0;
      // Stage 1 remembers whether this tick's data comes from RAM or pass-through
      stg_vld_d  = sample_tick;
      stg_play_d = (state_q == S_PLAY);
      vld_out_d  = stg_vld_q;
      out_d      = out_q;
      if (stg_vld_q) begin
         out_d = stg_play_q ? rd_data_q : pass_q;
      end

      case (state_q)
         S_IDLE: begin
            if (sample_tick) begin
               pass_d = sample_in;
            end
            if (rec_rise) begin
               state_d = S_RECORD;
            end else if (play && !record && (loop_len_q != '0)) begin
               state_d = S_PLAY;
            end
         end
         S_RECORD: begin
            if (sample_tick) begin
               pass_d = sample_in;
               if (loop_len_q != LEN_FULL) begin
                  mem_we     = 1'b1;
                  wr_ptr_d   = wr_ptr_q + 1'b1;
                  loop_len_d = loop_len_q + 1'b1;
               end
            end
            if (!record || (sample_tick && (loop_len_q == LEN_LAST))) begin
               state_d = S_IDLE;
            end
         end
         S_PLAY: begin
            if (sample_tick) begin
               rd_data_d = mem[rd_ptr_q];
               rd_ptr_d  = ({1'b0, rd_ptr_q} == len_minus1) ? '0 : rd_ptr_q + 1'b1;
            end
            if (rec_rise) begin
               state_d = S_RECORD;
            end else if (!play) begin
               state_d = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase

      // Entry actions override the tick bookkeeping of the departing state
      if ((state_d == S_RECORD) && (state_q != S_RECORD)) begin
         wr_ptr_d   = '0;
         loop_len_d = '0;
      end
      if ((state_d == S_PLAY) && (state_q != S_PLAY)) begin
         rd_ptr_d = '0;
      end
   end

   always_ff @(posedge CLOCK_50 or negedge reset_n) begin
      if (!reset_n) begin
         state_q    <= S_IDLE;
         record_q   <= 1'b0;
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         loop_len_q <= '0;
         pass_q     <= '0;
         rd_data_q  <= '0;
         stg_vld_q  <= 1'b0;
         stg_play_q <= 1'b0;
         out_q      <= '0;
         vld_out_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         record_q   <= record_d;
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         loop_len_q <= loop_len_d;
         pass_q     <= pass_d;
         rd_data_q  <= rd_data_d;
         stg_vld_q  <= stg_vld_d;
         stg_play_q <= stg_play_d;
         out_q      <= out_d;
         vld_out_q  <= vld_out_d;
      end
   end

   // Loop storage is intentionally not reset; loop_length gates playback
   always_ff @(posedge CLOCK_50) begin
      if (mem_we) begin
         mem[wr_ptr_q] <= sample_in;
      end
   end

   assign left_channel_audio_out  = out_q[63:32];
   assign right_channel_audio_out = out_q[31:0];
   assign sample_valid_out        = vld_out_q;
   assign loop_length             = loop_len_q;
   assign state                   = state_q;

endmodule
`default_nettype wire

// File: tb/tb_loop_recorder.sv
`default_nettype none
// tb_loop_recorder -- directed scoreboard bench for loop_recorder at ADDR_W=2.
module tb_loop_recorder;

   localparam int ADDR_W = 2;

   logic          clk = 1'b0;
   logic          reset_n;
   logic          sample_tick;
   logic [31:0]   in_l, in_r;
   logic          record, play;
   logic [31:0]   out_l, out_r;
   logic          valid;
   logic [ADDR_W:0] loop_length;
   logic [1:0]    state;

   int            n_checks = 0;
   int            n_errors = 0;
   logic [63:0]   sb_q[$];

   always #5 clk = ~clk;

   loop_recorder #(.ADDR_W(ADDR_W)) dut (
      .CLOCK_50                (clk),
      .reset_n                 (reset_n),
      .sample_tick             (sample_tick),
      .left_channel_audio_in   (in_l),
      .right_channel_audio_in  (in_r),
      .record                  (record),
      .play                    (play),
      .left_channel_audio_out  (out_l),
      .right_channel_audio_out (out_r),
      .sample_valid_out        (valid),
      .loop_length             (loop_length),
      .state                   (state)
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // One tick with inputs l/r; exp_l/exp_r is what must emerge two cycles later.
   task automatic tick(input logic [31:0] l, input logic [31:0] r,
                       input logic [31:0] exp_l, input logic [31:0] exp_r);
      logic [63:0] e;
      sb_q.push_back({exp_l, exp_r});
      in_l = l;
      in_r = r;
      sample_tick = 1'b1;
      step();
      sample_tick = 1'b0;
      chk("valid_early", {63'd0, valid}, 64'd0);
      step();
      chk("valid_pulse", {63'd0, valid}, 64'd1);
      chk("sb_size", 64'(sb_q.size()), 64'd1);
      if (sb_q.size() > 0) begin
         e = sb_q.pop_front();
         chk("data_out", {out_l, out_r}, e);
      end
      step();
      chk("valid_end", {63'd0, valid}, 64'd0);
      chk("data_hold", {out_l, out_r}, {exp_l, exp_r});
   endtask

   initial begin
      reset_n = 1'b0;
      sample_tick = 1'b0;
      in_l = '0;
      in_r = '0;
      record = 1'b0;
      play = 1'b0;
      #1;
      chk("rst_out", {out_l, out_r}, 64'd0);
      chk("rst_valid", {63'd0, valid}, 64'd0);
      chk("rst_state", {62'd0, state}, 64'd0);
      chk("rst_len", 64'(loop_length), 64'd0);
      step();
      step();
      reset_n = 1'b1;
      step();

      // IDLE pass-through
      tick(32'h11, 32'h22, 32'h11, 32'h22);
      chk("idle_state", {62'd0, state}, 64'd0);

      // Record three samples, then loop them
      record = 1'b1;
      step();
      chk("rec_state", {62'd0, state}, 64'd1);
      chk("rec_len0", 64'(loop_length), 64'd0);
      for (int i = 1; i <= 3; i++) begin
         tick(32'(i), 32'(i + 'h100), 32'(i), 32'(i + 'h100));
      end
      chk("rec3_len", 64'(loop_length), 64'd3);
      record = 1'b0;
      step();
      chk("rec3_idle", {62'd0, state}, 64'd0);
      play = 1'b1;
      step();
      chk("play_state", {62'd0, state}, 64'd2);
      for (int i = 0; i < 7; i++) begin
         tick(32'hAA, 32'hBB, 32'((i % 3) + 1), 32'((i % 3) + 1 + 'h100));
      end
      chk("play3_len", 64'(loop_length), 64'd3);
      play = 1'b0;
      step();
      chk("play_stop", {62'd0, state}, 64'd0);

      // Full recording with record held high
      record = 1'b1;
      step();
      chk("full_rec_state", {62'd0, state}, 64'd1);
      for (int i = 10; i <= 13; i++) begin
         tick(32'(i), 32'(i + 'h200), 32'(i), 32'(i + 'h200));
      end
      chk("full_exit", {62'd0, state}, 64'd0);
      chk("full_len", 64'(loop_length), 64'd4);
      tick(32'd14, 32'h20E, 32'd14, 32'h20E);
      tick(32'd15, 32'h20F, 32'd15, 32'h20F);
      chk("no_restart", {62'd0, state}, 64'd0);
      chk("len_sat", 64'(loop_length), 64'd4);
      record = 1'b0;
      step();
      play = 1'b1;
      step();
      chk("full_play_state", {62'd0, state}, 64'd2);
      for (int i = 0; i < 5; i++) begin
         tick(32'h0, 32'h0, 32'(10 + (i % 4)), 32'(10 + (i % 4) + 'h200));
      end

      // Record and play together in PLAY: record wins, loop cleared
      record = 1'b1;
      step();
      chk("rp_state", {62'd0, state}, 64'd1);
      chk("rp_len", 64'(loop_length), 64'd0);
      record = 1'b0;
      play = 1'b0;
      step();
      chk("rp_idle", {62'd0, state}, 64'd0);

      // Play with empty loop stays IDLE and keeps passing through
      play = 1'b1;
      step();
      step();
      chk("empty_play", {62'd0, state}, 64'd0);
      tick(32'h55, 32'h66, 32'h55, 32'h66);
      play = 1'b0;

      // Record two samples, play, then reset mid-PLAY
      record = 1'b1;
      step();
      tick(32'h31, 32'h41, 32'h31, 32'h41);
      tick(32'h32, 32'h42, 32'h32, 32'h42);
      record = 1'b0;
      step();
      play = 1'b1;
      step();
      chk("rst_play_state", {62'd0, state}, 64'd2);
      tick(32'h0, 32'h0, 32'h31, 32'h41);
      #3;
      reset_n = 1'b0;
      #1;
      chk("async_out", {out_l, out_r}, 64'd0);
      chk("async_state", {62'd0, state}, 64'd0);
      chk("async_len", 64'(loop_length), 64'd0);
      step();
      reset_n = 1'b1;
      step();
      step();
      chk("post_rst_state", {62'd0, state}, 64'd0);
      play = 1'b0;
      chk("sb_drained", 64'(sb_q.size()), 64'd0);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
`default_nettype wire
